cacheline_adaptor: RTL
======================

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameter LINE_W, default 256: cache line width in bits.
REQ-002 Parameter BURST_W, default 64: memory beat width in bits; BEATS = LINE_W/BURST_W = 4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 line_i  input  LINE_W  write line from the L1 cache (pmem_wdata side).
REQ-006 line_o  output  LINE_W  read line to the L1 cache (pmem_rdata side).
REQ-007 address_i  input  32  line request address from the cache.
REQ-008 read_i / write_i  input  1 each  cache line read/write request, held high until resp_o.
REQ-009 resp_o  output  1  one-cycle completion pulse to the cache.
REQ-010 burst_i  input  BURST_W  read beat from memory.
REQ-011 burst_o  output  BURST_W  write beat to memory.
REQ-012 address_o  output  32  line-aligned memory address.
REQ-013 read_o / write_o  output  1 each  memory burst request.
REQ-014 resp_i  input  1  memory beat strobe; one beat transferred per high cycle.

Function
REQ-015 FSM states: IDLE, READ, WRITE, DONE.
REQ-016 IDLE: read_i or write_i high -> latch address_i with bits [4:0] cleared, clear beat counter, go READ or WRITE; write_i has priority when both are high.
REQ-017 IDLE: write_i high also latches line_i into the write buffer in the same cycle.
REQ-018 address_o always drives the latched address; it is stable for the entire burst.
REQ-019 READ: read_o=1; each resp_i-high cycle stores burst_i into beat[counter] (beat 0 = bits [63:0]) and increments the counter.
REQ-020 WRITE: write_o=1, burst_o = buffer beat[counter]; each resp_i-high cycle increments the counter.
REQ-021 resp_i low mid-burst is a stall: counter, buffer and outputs hold; the request remains asserted.
REQ-022 On the resp_i cycle of beat BEATS-1, go DONE; read_o/write_o deassert the following cycle.
REQ-023 DONE: resp_o=1 for exactly one cycle, then return to IDLE.
REQ-024 Requests are not sampled in DONE, so a held read_i/write_i does not restart a transfer.
REQ-025 Minimum request-to-resp_o latency is BEATS+2 cycles: 1 cycle IDLE latch, 4 beats, 1 cycle DONE.
REQ-026 line_o = read assembly buffer, valid from the DONE cycle and held until the next read's first beat.
REQ-027 resp_i high in IDLE or DONE is ignored.
REQ-028 The counter is $clog2(BEATS) bits and wraps only on the terminal beat.

Reset
REQ-029 When rst is low: state=IDLE, counter=0, read_o=write_o=resp_o=0, buffers=0; consequently line_o=0, burst_o=0, address_o=0.
REQ-030 Reset mid-burst abandons the transfer immediately without completing the burst; no resp_o is issued.

Structure
REQ-031 A shared package cache_adaptor_pkg holds the FSM state enum and the LINE_W, BURST_W and BEATS constants.
REQ-032 The block is a single module with no sub-modules; it is instantiated between the L1 cache's pmem_* ports and physical memory.

Verification
REQ-033 Read, no stall: address_i=0x1234_5678, beats 0x11..,0x22..,0x33..,0x44.. on 4 consecutive resp_i -> address_o=0x1234_5660; resp_o at cycle 6; line_o={0x44..,0x33..,0x22..,0x11..}.
REQ-034 Write: line_i=256'hDEAD...BEEF -> burst_o presents beats [63:0],[127:64],[191:128],[255:192] in order, with write_o high 4 resp_i cycles, then a single resp_o pulse.
REQ-035 Stall: resp_i pattern 1,0,0,1,1,0,1 -> exactly 4 beats captured in order; resp_o one cycle after the last beat; address_o stable throughout.
REQ-036 Simultaneous read_i=write_i=1 in IDLE -> WRITE taken; read_o stays 0.
REQ-037 rst asserted after beat 2 of a read -> outputs zero asynchronously; no resp_o; a subsequent read completes normally.
REQ-038 read_i held high through DONE -> exactly one resp_o and no second read_o until IDLE re-samples.

Source files
------------

// File: rtl/cache_adaptor_pkg.sv
// Shared constants and FSM state encoding for the L1-to-memory cache line adaptor.
package cache_adaptor_pkg;

  localparam int LINE_W   = 256;
  localparam int BURST_W  = 64;
  localparam int BEATS    = LINE_W / BURST_W;
  localparam int CNT_W    = $clog2(BEATS);
  localparam int OFFSET_W = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one cache line read/write request into a BEATS-long memory burst
// and answers the cache with a single resp_o pulse once the burst is complete.
module cacheline_adaptor
  import cache_adaptor_pkg::state_e;
  import cache_adaptor_pkg::IDLE;
  import cache_adaptor_pkg::READ;
  import cache_adaptor_pkg::WRITE;
  import cache_adaptor_pkg::DONE;
#(
  parameter int LINE_W  = cache_adaptor_pkg::LINE_W,
  parameter int BURST_W = cache_adaptor_pkg::BURST_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i,
  output logic [1:0]         state_o
);

  localparam int BEATS    = LINE_W / BURST_W;
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFSET_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  // Handshake: the cache holds read_i/write_i until it sees the one-cycle
  // resp_o; memory moves exactly one beat on every cycle read_o/write_o and
  // resp_i are both high, and a low resp_i simply stalls the burst.
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [LINE_W-1:0]   wbuf_q, wbuf_d;
  logic [LINE_W-1:0]   rbuf_q, rbuf_d;
  logic                last_beat;

  assign last_beat = (cnt_q == LAST_BEAT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    rbuf_d  = rbuf_q;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (write_i || read_i) begin
          addr_d = {address_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
          cnt_d  = '0;
          if (write_i) begin
            state_d = WRITE;
            wbuf_d  = line_i;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        read_o = 1'b1;
        if (resp_i) begin
          rbuf_d[cnt_q*BURST_W +: BURST_W] = burst_i;
          cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
          if (last_beat) state_d = DONE;
        end
      end
      WRITE: begin
        write_o = 1'b1;
        if (resp_i) begin
          cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
          if (last_beat) state_d = DONE;
        end
      end
      // Requests are deliberately not looked at here so a held request
      // cannot immediately relaunch the transfer it just completed.
      DONE: begin
        resp_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      rbuf_q  <= rbuf_d;
    end
  end

  assign burst_o   = wbuf_q[cnt_q*BURST_W +: BURST_W];
  assign line_o    = rbuf_q;
  assign address_o = addr_q;
  assign state_o   = state_q;

endmodule
